// File: rtl/matrix_pkg.sv
// Shared types for the 5x7 status LED matrix scanner.
// Holds matrix state codes, geometry and the scanner FSM encoding.
package matrix_pkg;

  localparam int COLUMN_COUNT = 5;
  localparam int ROW_COUNT    = 7;

  typedef enum logic [2:0] {
    FILLING  = 3'b000,
    CLEANING = 3'b001,
    ERROR    = 3'b010,
    SPLINKER = 3'b011,
    DRIPPER  = 3'b100
  } matrix_state_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLANK,
    DRIVE
  } scan_state_e;

  typedef logic [ROW_COUNT-1:0] row_t;

endpackage

// File: rtl/matrix_slot_timer.sv
// Column slot counter: runs 0..TICK_DIVISOR-1 and wraps at each slot.
// Strobes mark the last blanking cycle and the last cycle of the slot.
module matrix_slot_timer #(
  parameter int TICK_DIVISOR = 5000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  localparam int W =
    (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;
  localparam logic [W-1:0] SLOT_LAST =
    W'(TICK_DIVISOR - 1);
  localparam logic [W-1:0] BLANK_LAST =
    W'(BLANK_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign blank_done = (cnt == BLANK_LAST);
  assign slot_done  = (cnt == SLOT_LAST);

endmodule

// File: rtl/matrix_column_scanner.sv
// Time-multiplexed 5x7 LED matrix column scanner with per-slot blanking.
// Optional error blink: define MATRIX_ERROR_BLINK_EN.
module matrix_column_scanner
  import matrix_pkg::*;
#(
  parameter int TICK_DIVISOR = 5000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] state,
  input  logic [6:0] column_4,
  input  logic [6:0] column_3,
  input  logic [6:0] column_2,
  input  logic [6:0] column_1,
  input  logic [6:0] column_0,
  output logic [4:0] column_select,
  output logic [6:0] row,
  output logic       frame_done
);

  scan_state_e fsm;
  logic [2:0]  col_idx;
  row_t [COLUMN_COUNT-1:0] frame_buf;
  row_t [COLUMN_COUNT-1:0] cols_in;

  logic blank_done;
  logic slot_done;
  logic timer_clear;
  logic frame_end;
  logic lit;

  assign cols_in = {column_4, column_3, column_2,
                    column_1, column_0};

  assign timer_clear = !enable || (fsm == IDLE) ||
                       (fsm == LOAD);

  assign frame_end = (fsm == DRIVE) && slot_done &&
                     (col_idx == 3'd0);

  matrix_slot_timer #(
    .TICK_DIVISOR(TICK_DIVISOR),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (timer_clear),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

`ifdef MATRIX_ERROR_BLINK_EN
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          blink_phase;
  logic [BW-1:0] blink_cnt;
  logic [2:0]    cap_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_phase <= 1'b1;
      blink_cnt   <= '0;
      cap_state   <= FILLING;
    end else if (fsm == LOAD) begin
      cap_state <= state;
      if (state != ERROR) begin
        blink_phase <= 1'b1;
        blink_cnt   <= '0;
      end
    end else if (frame_end && cap_state == ERROR) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign lit = blink_phase;
`else
  logic unused_state;
  assign unused_state = ^state;
  assign lit = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm           <= IDLE;
      column_select <= 5'b11111;
      row           <= '0;
      frame_done    <= 1'b0;
      col_idx       <= 3'd4;
      frame_buf     <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (fsm)
        IDLE: begin
          column_select <= 5'b11111;
          row           <= '0;
          if (enable) fsm <= LOAD;
        end
        LOAD: begin
          frame_buf <= cols_in;
          col_idx   <= 3'd4;
          fsm       <= enable ? BLANK : IDLE;
        end
        BLANK: begin
          if (!enable) begin
            fsm <= IDLE;
          end else if (blank_done) begin
            fsm <= DRIVE;
            if (lit) begin
              column_select <= ~(5'b00001 << col_idx);
              row           <= frame_buf[col_idx];
            end
          end
        end
        DRIVE: begin
          // a completed frame reports even if enable just fell
          if (frame_end) begin
            frame_done    <= 1'b1;
            column_select <= 5'b11111;
            row           <= '0;
            fsm           <= enable ? LOAD : IDLE;
          end else if (!enable) begin
            column_select <= 5'b11111;
            row           <= '0;
            fsm           <= IDLE;
          end else if (slot_done) begin
            column_select <= 5'b11111;
            row           <= '0;
            col_idx       <= col_idx - 3'd1;
            fsm           <= BLANK;
          end
        end
        default: begin
          column_select <= 5'b11111;
          row           <= '0;
          fsm           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Directed bench for matrix_column_scanner (TICK 8, BLANK 2, BLINK 2).
// Blink frames are checked when MATRIX_ERROR_BLINK_EN is defined.
module tb_matrix_column_scanner;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [2:0] state;
  logic [6:0] column_4, column_3, column_2;
  logic [6:0] column_1, column_0;
  logic [4:0] column_select;
  logic [6:0] row;
  logic       frame_done;

  int n_run;
  int n_fail;
  int cyc;
  logic [6:0] img [5];

  matrix_column_scanner #(
    .TICK_DIVISOR(8),
    .BLANK_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .state        (state),
    .column_4     (column_4),
    .column_3     (column_3),
    .column_2     (column_2),
    .column_1     (column_1),
    .column_0     (column_0),
    .column_select(column_select),
    .row          (row),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_cs"}, 32'(column_select), 32'h1f);
    check({tag, "_row"}, 32'(row), 32'h0);
  endtask

  // Expected outputs for a frame whose LOAD cycle was load_cyc
  task automatic check_scan(input int load_cyc,
                            input bit lit);
    int off, slot, pos;
    logic [4:0] ecs;
    logic [6:0] erow;
    off  = cyc - load_cyc - 1;
    ecs  = 5'b11111;
    erow = 7'h00;
    if (off >= 0 && off < 40) begin
      slot = off / 8;
      pos  = off % 8;
      if (pos >= 2 && lit) begin
        ecs  = ~(5'b00001 << (4 - slot));
        erow = img[4 - slot];
      end
    end
    check("scan_cs", 32'(column_select), 32'(ecs));
    check("scan_row", 32'(row), 32'(erow));
    check("scan_fd", 32'(frame_done), 32'(off == 40));
    check("onehot", 32'($countones(~column_select) <= 1),
          32'd1);
  endtask

  task automatic run_frame(input bit lit);
    int l;
    l = cyc;
    for (int k = 0; k < 41; k++) begin
      step();
      check_scan(l, lit);
    end
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    state    = 3'b000;
    column_4 = 7'b1111011;
    column_3 = 7'b1111101;
    column_2 = 7'b0000000;
    column_1 = 7'b1111101;
    column_0 = 7'b1111011;
    img[4] = 7'b1111011;
    img[3] = 7'b1111101;
    img[2] = 7'b0000000;
    img[1] = 7'b1111101;
    img[0] = 7'b1111011;

    #22;
    check_blank("rst0");
    check("rst0_fd", 32'(frame_done), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // reach a drive slot, then assert reset between edges
    enable = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("pre_rst_cs", 32'(column_select), 32'h0f);
    #2;
    reset_n = 1'b0;
    #1;
    check_blank("rst_async");
    check("rst_async_fd", 32'(frame_done), 32'h0);
    enable = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_blank("rst_hold");

    step();
    cyc = 0;
    check_blank("idle0");
    enable = 1'b1;
    step();
    check_blank("load1");
    check("load1_fd", 32'(frame_done), 32'h0);

    // frame 1: column_3 changes mid-frame without tearing
    for (int k = 0; k < 41; k++) begin
      step();
      check_scan(1, 1'b1);
      if (cyc == 4)
        check("c4_row", 32'(row), 32'h7b);
      if (cyc == 12)
        check("c12_cs", 32'(column_select), 32'h17);
      if (cyc == 10)
        column_3 = 7'b0110000;
    end
    check("fd42", 32'(frame_done), 32'h1);
    img[3] = 7'b0110000;

    // frame 2 shows the new column_3 image
    run_frame(1'b1);

    // frame 3: drop enable at relative cycle 14
    begin
      int l;
      l = cyc;
      for (int k = 0; k < 13; k++) begin
        step();
        check_scan(l, 1'b1);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_blank("drop");
      check("drop_fd", 32'(frame_done), 32'h0);
    end
    enable = 1'b1;
    step();
    check_blank("reload");
    check("reload_fd", 32'(frame_done), 32'h0);

    // three back-to-back frames from the restart
    for (int f = 0; f < 3; f++) run_frame(1'b1);

`ifdef MATRIX_ERROR_BLINK_EN
    state = 3'b010;
    run_frame(1'b1);
    run_frame(1'b1);
    run_frame(1'b0);
    run_frame(1'b0);
    run_frame(1'b1);
    run_frame(1'b1);
    state = 3'b011;
    run_frame(1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
